// File: rtl/adc_display_scanner.sv
// adc_display_scanner: rate-limited snapshot of the ADC word shown on a
// 4-digit common-anode multiplexed seven-segment display.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   data_in    16-bit ADC word, qualified by data_valid
//   mode       format select (00 hex, 01 BCD, 10 raw, 11 averaged)
//   data_valid one-cycle pulse marking a new data_in
//   blank_en   leading-zero blanking enable
//   an         digit anodes, active-low, an[0] is the rightmost digit
//   seg        segment cathodes {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   snapshot   word currently displayed
module adc_display_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 4,
   parameter int UPDATE_DIV  = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic [1:0]  mode,
   input  logic        data_valid,
   input  logic        blank_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [15:0] snapshot
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int UW = $clog2(UPDATE_DIV);

   localparam logic [1:0] MODE_BCD = 2'b01;

   logic [PW-1:0] pre_cnt;
   logic [UW-1:0] upd_cnt;
   logic [1:0]    idx;
   logic [1:0]    mode_q;
   logic          update_due;

   logic          pre_wrap;
   logic          upd_wrap;
   logic          in_guard;
   logic          capture;
   logic [3:0]    nib;
   logic          blank;
   logic [6:0]    glyph;

   logic [3:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   assign pre_wrap = (pre_cnt == PW'(REFRESH_DIV - 1));
   assign upd_wrap = (upd_cnt == UW'(UPDATE_DIV - 1));
   assign in_guard = (pre_cnt < PW'(GUARD));

   // A capture on the wrap cycle itself is allowed, so a pulse that lands
   // exactly on the period boundary is not lost.
   assign capture  = data_valid & (update_due | upd_wrap);

   assign nib = snapshot[{idx, 2'b00} +: 4];

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Digit k is a leading zero when nibbles k..3 are all zero;
   // the rightmost digit always shows so zero reads as "0".
   always_comb begin
      blank = 1'b0;
      if (blank_en && (mode_q != MODE_BCD)) begin
         unique case (idx)
            2'd0: blank = 1'b0;
            2'd1: blank = (snapshot[15:4] == 12'h000);
            2'd2: blank = (snapshot[15:8] == 8'h00);
            2'd3: blank = (snapshot[15:12] == 4'h0);
         endcase
      end
   end

   always_comb begin
      glyph = hex7(nib);
      if ((mode_q == MODE_BCD) && (nib > 4'd9))
         glyph = 7'h3F;
   end

   // Guard window: all anodes and segments off so the previous digit's
   // pattern cannot ghost onto the next anode while drivers settle.
   always_comb begin
      an_next  = 4'hF;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      if (!in_guard) begin
         an_next  = ~(4'b0001 << idx);
         seg_next = blank ? 7'h7F : glyph;
         dp_next  = ~((idx == 2'd3) && (mode_q == MODE_BCD));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upd_cnt    <= '0;
         update_due <= 1'b1;
         snapshot   <= 16'h0000;
         mode_q     <= 2'b00;
      end else begin
         upd_cnt <= upd_wrap ? '0 : upd_cnt + 1'b1;
         if (capture) begin
            snapshot   <= data_in;
            mode_q     <= mode;
            update_due <= 1'b0;
         end else if (upd_wrap) begin
            update_due <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
         idx     <= 2'd0;
         an      <= 4'hF;
         seg     <= 7'h7F;
         dp      <= 1'b1;
      end else begin
         pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
         if (pre_wrap)
            idx <= idx + 2'd1;
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_adc_display_scanner.sv
// tb_adc_display_scanner: directed bench for adc_display_scanner with a
// cycle-stamped scoreboard of expected display digits.
module tb_adc_display_scanner;

   localparam int RD = 8;
   localparam int GD = 2;
   localparam int UD = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic [1:0]  mode;
   logic        data_valid;
   logic        blank_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [15:0] snapshot;

   adc_display_scanner #(
      .REFRESH_DIV(RD),
      .GUARD(GD),
      .UPDATE_DIV(UD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .mode(mode),
      .data_valid(data_valid),
      .blank_en(blank_en),
      .an(an),
      .seg(seg),
      .dp(dp),
      .snapshot(snapshot)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      bit         chk_seg;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   last_cyc;
   int   n_assert;
   int   n_fail;

   // Check a sampled value against its expectation.
   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                       input logic d, input bit cs, input string tag);
      exp_t e;
      e.cyc = c;
      e.an = a;
      e.seg = s;
      e.dp = d;
      e.chk_seg = cs;
      e.tag = tag;
      sb.push_back(e);
      last_cyc = c;
   endtask

   // Output at cycle n reflects the scan position before edge n; pick the
   // middle of the next slot for digit k.
   task automatic push_digit(input int k, input logic [6:0] s,
                             input logic d, input string tag);
      int n;
      n = ((last_cyc > cyc) ? last_cyc : cyc) + 1;
      while (!((((n - 1) % RD) == 4) && ((((n - 1) / RD) % 4) == k)))
         n++;
      push(n, ~(4'b0001 << k), s, d, 1'b1, tag);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         chk({e.tag, ".an"}, {12'h0, an}, {12'h0, e.an});
         chk({e.tag, ".dp"}, {15'h0, dp}, {15'h0, e.dp});
         if (e.chk_seg)
            chk({e.tag, ".seg"}, {9'h0, seg}, {9'h0, e.seg});
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() > 0; i++)
         tick();
      chk("sb_empty", 16'(sb.size()), 16'h0);
   endtask

   // Advance until just after a period wrap, when an update is due.
   task automatic wait_due();
      do tick(); while ((cyc % UD) != 0);
   endtask

   task automatic capture(input logic [15:0] d, input logic [1:0] m,
                          input string tag);
      data_in = d;
      mode = m;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk(tag, snapshot, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] a_exp;
      n_assert = 0;
      n_fail = 0;
      cyc = 0;
      last_cyc = 0;
      reset = 1'b0;
      data_in = 16'h0;
      mode = 2'b00;
      data_valid = 1'b0;
      blank_en = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst0.an", {12'h0, an}, 16'h000F);
      chk("rst0.seg", {9'h0, seg}, 16'h007F);
      chk("rst0.dp", {15'h0, dp}, 16'h0001);
      chk("rst0.snap", snapshot, 16'h0000);

      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      capture(16'hFFFF, 2'b11, "pre_cap");
      while (cyc < 13) tick();
      chk("pre_rst.an", {12'h0, an}, 16'h000D);

      // Asynchronous reset mid-slot, between clock edges.
      #2;
      reset = 1'b0;
      #1;
      chk("arst.an", {12'h0, an}, 16'h000F);
      chk("arst.seg", {9'h0, seg}, 16'h007F);
      chk("arst.dp", {15'h0, dp}, 16'h0001);
      chk("arst.snap", snapshot, 16'h0000);

      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      last_cyc = 0;
      sb.delete();
      push(1, 4'hF, 7'h7F, 1'b1, 1'b0, "guard_c1");
      push(2, 4'hF, 7'h7F, 1'b1, 1'b0, "guard_c2");
      push(3, 4'hE, 7'h19, 1'b1, 1'b1, "first_c3");
      tick();
      capture(16'h1234, 2'b00, "first_cap");
      while (cyc < 6) tick();
      data_in = 16'h5678;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("rate_limit", snapshot, 16'h1234);

      for (int r = 0; r < 2; r++) begin
         push_digit(0, 7'h19, 1'b1, "h1234.d0");
         push_digit(1, 7'h30, 1'b1, "h1234.d1");
         push_digit(2, 7'h24, 1'b1, "h1234.d2");
         push_digit(3, 7'h79, 1'b1, "h1234.d3");
      end
      drain();

      wait_due();
      capture(16'h9ABC, 2'b00, "cap_9abc");
      push_digit(0, 7'h46, 1'b1, "h9abc.d0");
      push_digit(1, 7'h03, 1'b1, "h9abc.d1");
      push_digit(2, 7'h08, 1'b1, "h9abc.d2");
      push_digit(3, 7'h10, 1'b1, "h9abc.d3");
      drain();

      // Pulse landing exactly on the wrap cycle while no update is due.
      while ((cyc % UD) != (UD - 1)) tick();
      blank_en = 1'b1;
      capture(16'h0042, 2'b11, "wrap_cap");
      data_in = 16'h7777;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("wrap_due_clr", snapshot, 16'h0042);
      push_digit(0, 7'h24, 1'b1, "blk42.d0");
      push_digit(1, 7'h19, 1'b1, "blk42.d1");
      push_digit(2, 7'h7F, 1'b1, "blk42.d2");
      push_digit(3, 7'h7F, 1'b1, "blk42.d3");
      drain();

      wait_due();
      capture(16'h0000, 2'b11, "cap_zero");
      push_digit(0, 7'h40, 1'b1, "blk0.d0");
      push_digit(1, 7'h7F, 1'b1, "blk0.d1");
      push_digit(2, 7'h7F, 1'b1, "blk0.d2");
      push_digit(3, 7'h7F, 1'b1, "blk0.d3");
      drain();

      blank_en = 1'b0;
      for (int k = 0; k < 4; k++)
         push_digit(k, 7'h40, 1'b1, "noblk");
      drain();
      blank_en = 1'b1;

      wait_due();
      capture(16'h1250, 2'b01, "cap_bcd");
      push_digit(0, 7'h40, 1'b1, "bcd.d0");
      push_digit(1, 7'h12, 1'b1, "bcd.d1");
      push_digit(2, 7'h24, 1'b1, "bcd.d2");
      push_digit(3, 7'h79, 1'b0, "bcd.d3");
      drain();

      wait_due();
      capture(16'h0A05, 2'b01, "cap_bcd_err");
      mode = 2'b00;
      push_digit(0, 7'h12, 1'b1, "bcde.d0");
      push_digit(1, 7'h40, 1'b1, "bcde.d1");
      push_digit(2, 7'h3F, 1'b1, "bcde.d2");
      push_digit(3, 7'h40, 1'b0, "bcde.d3");
      drain();

      for (int i = 0; i < 4 * RD * 2; i++) begin
         tick();
         n = cyc - 1;
         if ((n % RD) < GD)
            a_exp = 4'hF;
         else
            a_exp = ~(4'b0001 << ((n / RD) % 4));
         chk("scan.an", {12'h0, an}, {12'h0, a_exp});
         if (a_exp == 4'hF)
            chk("guard.dp", {15'h0, dp}, 16'h0001);
         chk("onehot", 16'($countones(~an) <= 1), 16'h0001);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
